encoder_16to4_queue: RTL and testbench
======================================

ENCODER_16TO4_QUEUE -- requirements
Module: encoder_16to4_queue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk only.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in  input  16  event lines; in[i]=1 in a cycle posts one event for line i.
REQ-005 en  input  1  enable; 1 = capture events and issue codes, 0 = capture and issue frozen.
REQ-006 ready  input  1  consumer accepts the presented code this cycle.
REQ-007 dout  output  4  binary index of the issued event line, registered.
REQ-008 valid  output  1  dout holds an issued, not-yet-accepted event, registered.
REQ-009 pending  output  16  captured, not-yet-issued events (internal pend register).
REQ-010 count  output  5  population count of pending, 0..16, combinational from pend.
REQ-011 overflow  output  1  sticky flag; an event on a line was lost.

Function
REQ-012 Capture: when en=1, each edge SHALL update pend <= (pend & ~issue_mask) | in.
- issue_mask is the one-hot of the line issued that edge, or 0 if nothing is issued.
REQ-013 When en=0, in SHALL be ignored; pend, dout and valid SHALL hold, except for the acceptance rule in REQ-017.
REQ-014 Issue condition: en=1 AND pend!=0 AND (valid=0 OR ready=1).
REQ-015 Priority: the issued line SHALL be the lowest set index of the registered pend; same-cycle in SHALL NOT take part in selection.
REQ-016 On issue: dout <= index, valid <= 1, and that pend bit is cleared per REQ-012.
REQ-017 Acceptance: valid=1 AND ready=1 with no issue that edge SHALL give valid <= 0 and dout holds its last value; this rule SHALL also apply when en=0.
REQ-018 Back-to-back issue: with ready held at 1, one code SHALL be issued per cycle until pend=0.
REQ-019 Latency: an event on in at cycle N SHALL appear in pend after edge N and on dout/valid after edge N+1, at the earliest.
REQ-020 Set wins over clear: if in[i]=1 on the edge line i is issued, pend[i] SHALL remain 1 (new event), and overflow SHALL NOT be set.
REQ-021 Overflow: en=1, in[i]=1, pend[i]=1 and line i not issued that edge SHALL set overflow <= 1.
- overflow stays 1 until rst.
- The duplicate event is discarded.
REQ-022 An event for a line currently held in dout (valid=1) and not in pend SHALL be captured normally and SHALL NOT set overflow.
REQ-023 Control state machine:
- IDLE (valid=0) -> HOLD on issue.
- HOLD (valid=1) -> HOLD on issue or ready=0.
- HOLD -> IDLE on ready=1 with no issue.
REQ-024 dout and valid SHALL NOT change while valid=1 and ready=0 (stable-until-accepted).

Reset
REQ-025 rst=1 at an edge SHALL force pend=0, dout=4'b0000, valid=0 and overflow=0, regardless of en, in and ready; count therefore reads 0.
REQ-026 Reset mid-operation SHALL discard all pending and held events; events on in in the reset cycle SHALL NOT be captured.
REQ-027 In the first cycle after rst deasserts, normal capture SHALL resume.

Verification
REQ-028 Reset, then en=1, in=16'h0008 for one cycle, ready=1 -> pend=16'h0008 after edge 1; dout=3, valid=1 after edge 2; valid=0 after edge 3.
REQ-029 in=16'h8421 in one cycle, ready=1 -> dout sequence 0, 5, 10, 15 on consecutive cycles, count 4,3,2,1,0, then valid=0.
REQ-030 ready=0 with in=16'h0006 -> dout=1, valid=1 held stable for 5 cycles, pend=16'h0004; after ready=1, next code is dout=2.
REQ-031 pend[3]=1 and ready=0, in=16'h0008 again -> overflow=1 and stays 1 until rst; pend unchanged.
REQ-032 en=0 with in=16'hFFFF and valid=1, ready=1 -> valid drops to 0, pend unchanged, no capture; rst mid-stream -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/encoder_16to4_queue.sv
// Queued 16-to-4 priority encoder: captures event lines into a pending register
// and issues the lowest pending index through a registered valid/ready handshake.
module encoder_16to4_queue (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in,
  input  logic        en,
  input  logic        ready,
  output logic [3:0]  dout,
  output logic        valid,
  output logic [15:0] pending,
  output logic [4:0]  count,
  output logic        overflow
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [15:0] pend_q, pend_d;
  logic [3:0]  dout_q, dout_d;
  logic        overflow_q, overflow_d;

  logic [3:0]  sel_idx;
  logic        issue;
  logic [15:0] issue_mask;

  // Lowest set index of the registered pend; same-cycle inputs never compete.
  always_comb begin
    // NOTE: every variable gets a default first so always_comb cannot infer a latch.
    sel_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (pend_q[i]) sel_idx = 4'(i);
    end
  end

  always_comb begin
    count = 5'd0;
    for (int i = 0; i < 16; i++) begin
      count = count + {4'd0, pend_q[i]};
    end
  end

  assign issue      = en && (pend_q != 16'd0) && (state_q == IDLE || ready);
  assign issue_mask = issue ? (16'd1 << sel_idx) : 16'd0;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    dout_d     = dout_q;
    overflow_d = overflow_q;

    if (en) begin
      // A new event on the line being issued survives (set wins over clear).
      pend_d = (pend_q & ~issue_mask) | in;
      if ((in & pend_q & ~issue_mask) != 16'd0) overflow_d = 1'b1;
    end

    if (issue) begin
      dout_d  = sel_idx;
      state_d = HOLD;
    end else if (state_q == HOLD && ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all registers
    // update together from pre-edge values.
    if (rst) begin
      state_q    <= IDLE;
      pend_q     <= 16'd0;
      dout_q     <= 4'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      dout_q     <= dout_d;
      overflow_q <= overflow_d;
    end
  end

  assign dout     = dout_q;
  assign valid    = (state_q == HOLD);
  assign pending  = pend_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_encoder_16to4_queue.sv
// Directed bench for encoder_16to4_queue: hand-computed expectations checked
// with immediate assertions one step after each rising edge.
module tb_encoder_16to4_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in;
  logic        en;
  logic        ready;
  logic [3:0]  dout;
  logic        valid;
  logic [15:0] pending;
  logic [4:0]  count;
  logic        overflow;

  int total  = 0;
  int passed = 0;

  encoder_16to4_queue dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .en       (en),
    .ready    (ready),
    .dout     (dout),
    .valid    (valid),
    .pending  (pending),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic [3:0] e_dout, input logic e_valid,
                      input logic [15:0] e_pend, input logic e_ovf);
    check({tag, ".dout"},     {12'd0, dout},     {12'd0, e_dout});
    check({tag, ".valid"},    {15'd0, valid},    {15'd0, e_valid});
    check({tag, ".pending"},  pending,           e_pend);
    check({tag, ".overflow"}, {15'd0, overflow}, {15'd0, e_ovf});
  endtask

  initial begin
    // Reset wins over active inputs.
    rst = 1'b1; en = 1'b1; in = 16'hFFFF; ready = 1'b1;
    tick();
    outs("reset", 4'd0, 1'b0, 16'h0000, 1'b0);
    check("reset.count", {11'd0, count}, 16'd0);

    // Single event latency.
    rst = 1'b0; in = 16'h0008;
    tick();
    outs("lat.e1", 4'd0, 1'b0, 16'h0008, 1'b0);
    check("lat.e1.count", {11'd0, count}, 16'd1);
    in = 16'h0000;
    tick();
    outs("lat.e2", 4'd3, 1'b1, 16'h0000, 1'b0);
    tick();
    outs("lat.e3", 4'd3, 1'b0, 16'h0000, 1'b0);

    // Back-to-back issue of 16'h8421.
    in = 16'h8421;
    tick();
    check("b2b.count0", {11'd0, count}, 16'd4);
    in = 16'h0000;
    tick();
    outs("b2b.i0", 4'd0, 1'b1, 16'h8420, 1'b0);
    check("b2b.count1", {11'd0, count}, 16'd3);
    tick();
    outs("b2b.i1", 4'd5, 1'b1, 16'h8400, 1'b0);
    check("b2b.count2", {11'd0, count}, 16'd2);
    tick();
    outs("b2b.i2", 4'd10, 1'b1, 16'h8000, 1'b0);
    check("b2b.count3", {11'd0, count}, 16'd1);
    tick();
    outs("b2b.i3", 4'd15, 1'b1, 16'h0000, 1'b0);
    check("b2b.count4", {11'd0, count}, 16'd0);
    tick();
    outs("b2b.done", 4'd15, 1'b0, 16'h0000, 1'b0);

    // Stall: output stable while ready=0.
    ready = 1'b0; in = 16'h0006;
    tick();
    outs("stall.cap", 4'd15, 1'b0, 16'h0006, 1'b0);
    in = 16'h0000;
    tick();
    outs("stall.iss", 4'd1, 1'b1, 16'h0004, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      outs("stall.hold", 4'd1, 1'b1, 16'h0004, 1'b0);
    end
    ready = 1'b1;
    tick();
    outs("stall.next", 4'd2, 1'b1, 16'h0000, 1'b0);
    tick();
    outs("stall.done", 4'd2, 1'b0, 16'h0000, 1'b0);

    // Event for the line held in dout is captured without overflow.
    ready = 1'b0; in = 16'h0010;
    tick();
    in = 16'h0000;
    tick();
    outs("held.iss", 4'd4, 1'b1, 16'h0000, 1'b0);
    in = 16'h0010;
    tick();
    outs("held.cap", 4'd4, 1'b1, 16'h0010, 1'b0);
    in = 16'h0000; ready = 1'b1;
    tick();
    outs("held.reiss", 4'd4, 1'b1, 16'h0000, 1'b0);
    tick();
    outs("held.done", 4'd4, 1'b0, 16'h0000, 1'b0);

    // Set wins over clear, then overflow on a true duplicate.
    ready = 1'b0; in = 16'h0008;
    tick();
    outs("ovf.cap", 4'd4, 1'b0, 16'h0008, 1'b0);
    tick();
    outs("ovf.setwins", 4'd3, 1'b1, 16'h0008, 1'b0);
    tick();
    outs("ovf.dup", 4'd3, 1'b1, 16'h0008, 1'b1);
    in = 16'h0000;
    tick();
    outs("ovf.sticky", 4'd3, 1'b1, 16'h0008, 1'b1);
    ready = 1'b1;
    tick();
    outs("ovf.reiss", 4'd3, 1'b1, 16'h0000, 1'b1);
    tick();
    outs("ovf.drain", 4'd3, 1'b0, 16'h0000, 1'b1);

    // Acceptance while disabled; inputs ignored.
    ready = 1'b0; in = 16'h0003;
    tick();
    in = 16'h0000;
    tick();
    outs("dis.iss", 4'd0, 1'b1, 16'h0002, 1'b1);
    en = 1'b0; in = 16'hFFFF; ready = 1'b1;
    tick();
    outs("dis.accept", 4'd0, 1'b0, 16'h0002, 1'b1);
    tick();
    outs("dis.frozen", 4'd0, 1'b0, 16'h0002, 1'b1);

    // Reset mid-stream.
    en = 1'b1; in = 16'h0100; ready = 1'b0;
    tick();
    outs("mid.iss", 4'd1, 1'b1, 16'h0100, 1'b1);
    rst = 1'b1; in = 16'hFFFF;
    tick();
    outs("mid.rst", 4'd0, 1'b0, 16'h0000, 1'b0);
    check("mid.rst.count", {11'd0, count}, 16'd0);

    // Capture resumes immediately after reset.
    rst = 1'b0; in = 16'h0040; ready = 1'b1;
    tick();
    outs("post.cap", 4'd0, 1'b0, 16'h0040, 1'b0);
    in = 16'h0000; ready = 1'b0;
    tick();
    outs("post.iss", 4'd6, 1'b1, 16'h0000, 1'b0);

    // Full population count.
    in = 16'hFFFF;
    tick();
    outs("full", 4'd6, 1'b1, 16'hFFFF, 1'b0);
    check("full.count", {11'd0, count}, 16'd16);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
